gpio_ctrl: RTL

- Parametrised, register-mapped GPIO controller that succeeds the fixed switch-to-GPO / GPI-to-LED wiring.
- Per-input 2-FF synchroniser, programmable debounce, rising/falling edge detection and sticky interrupt status.
- Output register with atomic set/clear/toggle access.
- Sits on the RV32I core's peripheral bus; pins go to the board GPIO headers, switches and LEDs.

---
 rtl/gpio_pkg.sv | 14 +
 rtl/gpio_debounce.sv | 30 +++
 rtl/gpio_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register map indices and bus constants shared by the GPIO controller.
package gpio_pkg;
    localparam int DATA_W = 32;
    typedef logic [3:0] gpio_addr_t;
    localparam gpio_addr_t ADDR_IN_DATA     = 4'd0;
    localparam gpio_addr_t ADDR_OUT_DATA    = 4'd1;
    localparam gpio_addr_t ADDR_OUT_SET     = 4'd2;
    localparam gpio_addr_t ADDR_OUT_CLR     = 4'd3;
    localparam gpio_addr_t ADDR_OUT_TGL     = 4'd4;
    localparam gpio_addr_t ADDR_IRQ_RISE_EN = 4'd5;
    localparam gpio_addr_t ADDR_IRQ_FALL_EN = 4'd6;
    localparam gpio_addr_t ADDR_IRQ_STATUS  = 4'd7;
    localparam gpio_addr_t ADDR_DB_LIMIT    = 4'd8;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: 2-FF synchroniser plus hold-time debounce for one input pin.
module gpio_debounce #(
    parameter int DB_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pin,
    input  logic [DB_W-1:0] limit,
    output logic            db,
    output logic            rise_pulse,
    output logic            fall_pulse
);
    logic [1:0]      sync;
    logic [DB_W-1:0] cnt;
    logic            accept;
    // >= lets a lowered limit release a change that has already been held longer
    assign accept     = (sync[1] != db) && (cnt >= limit);
    assign rise_pulse = accept && sync[1];
    assign fall_pulse = accept && !sync[1];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            cnt  <= (sync[1] == db || accept) ? '0 : cnt + DB_W'(1);
            if (accept) db <= sync[1];
        end
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO block with debounced inputs, edge interrupts
// and set/clear/toggle output access.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int              N_IN   = 10,
    parameter int              N_OUT  = 26,
    parameter int              DB_W   = 16,
    parameter logic [DB_W-1:0] DB_RST = '0
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  gpio_addr_t        bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_we,
    input  logic              bus_re,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rvalid,
    input  logic [N_IN-1:0]   gpi,
    output logic [N_OUT-1:0]  gpo,
    output logic              irq
);
    logic [N_IN-1:0]   db, rise, fall, rise_en, fall_en, status, status_next, wd_in, w1c;
    logic [N_OUT-1:0]  out_data, out_next, wd_out;
    logic [DB_W-1:0]   db_limit;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_wdata;

    genvar i;
    generate
        for (i = 0; i < N_IN; i++) begin : g_in
            gpio_debounce #(.DB_W(DB_W)) u_db (
                .clk       (CLOCK_50),
                .rst       (rst),
                .pin       (gpi[i]),
                .limit     (db_limit),
                .db        (db[i]),
                .rise_pulse(rise[i]),
                .fall_pulse(fall[i])
            );
        end
    endgenerate

    assign unused_wdata = ^bus_wdata;
    assign wd_in  = bus_wdata[N_IN-1:0];
    assign wd_out = bus_wdata[N_OUT-1:0];
    assign gpo    = out_data;

    assign out_next = !bus_we                        ? out_data :
                      bus_addr == ADDR_OUT_DATA      ? wd_out :
                      bus_addr == ADDR_OUT_SET       ? out_data | wd_out :
                      bus_addr == ADDR_OUT_CLR       ? out_data & ~wd_out :
                      bus_addr == ADDR_OUT_TGL       ? out_data ^ wd_out : out_data;

    // new edges are OR-ed in after the clear so a coincident event survives
    assign w1c         = (bus_we && bus_addr == ADDR_IRQ_STATUS) ? wd_in : '0;
    assign status_next = (status & ~w1c) | (rise & rise_en) | (fall & fall_en);

    assign rd_mux = bus_addr == ADDR_IN_DATA     ? DATA_W'(db) :
                    bus_addr == ADDR_OUT_DATA    ? DATA_W'(out_data) :
                    bus_addr == ADDR_IRQ_RISE_EN ? DATA_W'(rise_en) :
                    bus_addr == ADDR_IRQ_FALL_EN ? DATA_W'(fall_en) :
                    bus_addr == ADDR_IRQ_STATUS  ? DATA_W'(status) :
                    bus_addr == ADDR_DB_LIMIT    ? DATA_W'(db_limit) : '0;

    always_ff @(posedge CLOCK_50 or posedge rst)
        if (rst) begin
            out_data   <= '0;
            rise_en    <= '0;
            fall_en    <= '0;
            status     <= '0;
            db_limit   <= DB_RST;
            irq        <= 1'b0;
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
        end else begin
            out_data   <= out_next;
            status     <= status_next;
            irq        <= |status;
            bus_rvalid <= bus_re;
            if (bus_re) bus_rdata <= rd_mux;
            if (bus_we && bus_addr == ADDR_IRQ_RISE_EN) rise_en <= wd_in;
            if (bus_we && bus_addr == ADDR_IRQ_FALL_EN) fall_en <= wd_in;
            if (bus_we && bus_addr == ADDR_DB_LIMIT) db_limit <= bus_wdata[DB_W-1:0];
        end
endmodule
